// File: rtl/vector_ram_bank_ctrl_if.sv
// Vector RAM request/response bundle shared by the RAM path stages.
// Master drives requests and rready; slave returns ready and read data.
interface vector_ram_if #(
  parameter int PARALLELISM = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
) ();

  logic                  valid;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr  [PARALLELISM];
  logic [DATA_WIDTH-1:0] wdata [PARALLELISM];
  logic                  ready;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata [PARALLELISM];

  modport master (
    output valid, write, addr, wdata, rready,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, addr, wdata, rready,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/vector_ram_bank_ctrl.sv
// Banked vector RAM: one RAM per lane, fixed-latency read pipeline and
// a credit-protected response FIFO so no read data is lost on stalls.
module vector_ram_bank_ctrl #(
  parameter int PARALLELISM  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input logic         clk,
  input logic         rst_n,
  vector_ram_if.slave ram
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] RESP_MAX = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] word_t;

  if (RESP_DEPTH < READ_LATENCY + 1) begin : g_bad_resp
    $error("RESP_DEPTH must be >= READ_LATENCY+1");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be in 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2");
  end

  logic [CW-1:0]           occ;
  logic [CW-1:0]           fcnt;
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           rptr;
  logic [READ_LATENCY-1:0] vld;

  word_t pipe_out;
  word_t head;
  word_t fifo_mem [RESP_DEPTH];

  logic rdy;
  logic acc;
  logic wr_acc;
  logic rd_acc;
  logic push;
  logic pop;
  logic not_empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // occ covers reads in flight plus queued, so a credit guarantees room
  assign rdy       = rst_n && (occ < RESP_MAX);
  assign acc       = ram.valid && rdy;
  assign wr_acc    = acc && ram.write;
  assign rd_acc    = acc && !ram.write;
  assign not_empty = rst_n && (fcnt != '0);
  assign pop       = not_empty && ram.rready;
  assign push      = vld[READ_LATENCY-1];
  assign head      = fifo_mem[rptr];

  assign ram.ready  = rdy;
  assign ram.rvalid = not_empty;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] stg [READ_LATENCY];
    logic [IW-1:0]         idx;

    assign idx = ram.addr[i][IW-1:0];

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        mem[idx] <= ram.wdata[i];
      end
      if (rd_acc) begin
        stg[0] <= mem[idx];
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        stg[s] <= stg[s-1];
      end
    end

    assign pipe_out[i]  = stg[READ_LATENCY-1];
    assign ram.rdata[i] = not_empty ? head[i] : '0;

    if (ADDR_WIDTH > IW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ram.addr[i][ADDR_WIDTH-1:IW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= '0;
      fcnt <= '0;
      wptr <= '0;
      rptr <= '0;
      vld  <= '0;
    end else begin
      vld[0] <= rd_acc;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld[s] <= vld[s-1];
      end
      unique case ({rd_acc, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      if (push) begin
        wptr <= nxt(wptr);
      end
      if (pop) begin
        rptr <= nxt(rptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr] <= pipe_out;
    end
  end

endmodule

// File: tb/tb_vector_ram_bank_ctrl.sv
// Bench for vector_ram_bank_ctrl: queue-based response model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_vector_ram_bank_ctrl;

  localparam int P     = 4;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int RL    = 2;
  localparam int RD    = 4;

  typedef logic [P-1:0][DW-1:0] word_t;
  typedef logic [P-1:0][3:0]    addr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_ram_if #(
    .PARALLELISM(P),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) ram_if ();

  vector_ram_bank_ctrl #(
    .PARALLELISM (P),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(RL),
    .RESP_DEPTH  (RD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ram  (ram_if)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic word_t rd_pk();
    word_t v;
    for (int i = 0; i < P; i++) v[i] = ram_if.rdata[i];
    return v;
  endfunction

  function automatic addr_t all_a(input int a);
    addr_t v;
    for (int i = 0; i < P; i++) v[i] = 4'(a);
    return v;
  endfunction

  function automatic logic [31:0] pf(input int i, input int a);
    return {8'(i + 1), 16'h0000, 8'(a)};
  endfunction

  // Model: outstanding reads in order, each visible from its due cycle
  typedef struct {
    word_t data;
    int    avail;
  } resp_t;

  resp_t mq[$];
  word_t mmem [DEPTH];

  always @(negedge clk) begin : model
    logic  e_ready;
    logic  e_rvalid;
    word_t e_rdata;
    resp_t r;
    e_ready  = rst_n && (mq.size() < RD);
    e_rvalid = rst_n && (mq.size() > 0) && (mq[0].avail <= cyc);
    e_rdata  = e_rvalid ? mq[0].data : '0;
    chk("ready", ram_if.ready, e_ready);
    chk("rvalid", ram_if.rvalid, e_rvalid);
    chk("rdata", rd_pk(), e_rdata);
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (e_rvalid && ram_if.rready) void'(mq.pop_front());
      if (ram_if.valid && e_ready) begin
        if (ram_if.write) begin
          for (int i = 0; i < P; i++)
            mmem[ram_if.addr[i][3:0]][i] = ram_if.wdata[i];
        end else begin
          for (int i = 0; i < P; i++)
            r.data[i] = mmem[ram_if.addr[i][3:0]][i];
          r.avail = cyc + RL + 1;
          mq.push_back(r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic w, input addr_t a,
                     input word_t d);
    ram_if.valid = v;
    ram_if.write = w;
    for (int i = 0; i < P; i++) begin
      ram_if.addr[i]  = 16'(a[i]);
      ram_if.wdata[i] = d[i];
    end
  endtask

  task automatic idle();
    req(1'b0, 1'b0, '0, '0);
  endtask

  task automatic read_wait(input string nm, input addr_t a,
                           input word_t exp);
    int lat;
    lat = 0;
    req(1'b0, 1'b0, '0, '0);
    req(1'b1, 1'b0, a, '0);
    step();
    idle();
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (ram_if.rvalid) lat = k;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_data"}, rd_pk(), exp);
    step();
  endtask

  initial begin
    word_t d;
    word_t first;
    int    acc;
    int    n;
    int    resp;
    int    stale;
    int    drops;
    int    fst;
    int    lst;

    idle();
    ram_if.rready = 1'b0;

    @(negedge clk);
    chk("rst_ready", ram_if.ready, 1'b0);
    chk("rst_rdata", rd_pk(), '0);
    step();
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_ready", ram_if.ready, 1'b1);
    step();

    for (int a = 0; a < DEPTH; a++) begin
      for (int i = 0; i < P; i++) d[i] = pf(i, a);
      req(1'b1, 1'b1, all_a(a), d);
      step();
    end
    idle();
    ram_if.rready = 1'b1;

    req(1'b1, 1'b1, {4'd3, 4'd2, 4'd1, 4'd0},
        {32'hD3, 32'hC2, 32'hB1, 32'hA0});
    step();
    req(1'b1, 1'b1, {4'd0, 4'd1, 4'd2, 4'd3},
        {32'hA0, 32'hB1, 32'hC2, 32'hD3});
    step();
    read_wait("wr_rb0", {4'd0, 4'd1, 4'd2, 4'd3},
              {32'hA0, 32'hB1, 32'hC2, 32'hD3});
    read_wait("wr_rb1", {4'd3, 4'd2, 4'd1, 4'd0},
              {32'hD3, 32'hC2, 32'hB1, 32'hA0});

    req(1'b1, 1'b1, all_a(5), {32'd4, 32'd3, 32'd2, 32'd1});
    step();
    read_wait("lane_ind", all_a(5), {32'd4, 32'd3, 32'd2, 32'd1});

    ram_if.rready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      req(1'b1, 1'b0, all_a(8 + k), '0);
      @(negedge clk);
      if (ram_if.ready) acc++;
      step();
    end
    idle();
    chk("bp_accepts", acc, 4);
    repeat (3) step();
    @(negedge clk);
    chk("bp_ready_low", ram_if.ready, 1'b0);
    first = rd_pk();
    chk("bp_head", first, {pf(3, 8), pf(2, 8), pf(1, 8), pf(0, 8)});
    step();
    step();
    @(negedge clk);
    chk("bp_stable", rd_pk(), first);
    step();
    ram_if.rready = 1'b1;
    @(negedge clk);
    chk("bp_pop_ready", ram_if.ready, 1'b0);
    first = rd_pk();
    chk("bp_order0", first[0], pf(0, 8));
    n = 1;
    step();
    @(negedge clk);
    chk("bp_ready_back", ram_if.ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (ram_if.rvalid && ram_if.rready) begin
        first = rd_pk();
        chk("bp_order", first[0], pf(0, 8 + n));
        n++;
      end
      @(negedge clk);
    end
    chk("bp_count", n, 4);
    step();

    fst   = -1;
    lst   = -1;
    resp  = 0;
    drops = 0;
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          req(1'b1, 1'b0, all_a(k % 16), '0);
          step();
        end
        idle();
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (c < 32 && !ram_if.ready) drops++;
          if (ram_if.rvalid) begin
            if (fst < 0) fst = c;
            lst = c;
            resp++;
          end
        end
      end
    join
    step();
    chk("st_drops", drops, 0);
    chk("st_resps", resp, 32);
    chk("st_first", fst, 3);
    chk("st_span", lst - fst, 31);

    ram_if.rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req(1'b1, 1'b0, all_a(12 + k), '0);
      step();
    end
    idle();
    repeat (4) step();
    ram_if.rready = 1'b1;
    acc  = 0;
    resp = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) req(1'b1, 1'b0, all_a(c), '0);
      else idle();
      @(negedge clk);
      if (ram_if.valid && ram_if.ready) acc++;
      if (ram_if.rvalid && ram_if.rready) resp++;
      step();
    end
    idle();
    chk("full_accepts", acc, 7);
    chk("full_resps", resp, 11);

    ram_if.rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req(1'b1, 1'b0, all_a(8 + k), '0);
      @(negedge clk);
      if (k == 3) chk("mid_inflight", ram_if.rvalid, 1'b1);
      step();
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", ram_if.ready, 1'b0);
    chk("mid_rst_rvalid", ram_if.rvalid, 1'b0);
    step();
    rst_n = 1'b1;
    ram_if.rready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ram_if.ready, 1'b1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (ram_if.rvalid) stale++;
      @(negedge clk);
    end
    chk("post_rst_stale", stale, 0);
    step();
    read_wait("post_rst_rd", all_a(5), {32'd4, 32'd3, 32'd2, 32'd1});
    read_wait("post_rst_pf", all_a(9),
              {pf(3, 9), pf(2, 9), pf(1, 9), pf(0, 9)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
